// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose:
//   Sequencer for an iterative AES-128 encryption engine. It accepts one
//   plaintext block at a time and does the initial AddRoundKey itself. It
//   then steps an external round datapath through rounds 1..10, giving each
//   round three cycles, and presents the ciphertext with a valid/ready
//   handshake.
//
// Ports:
//   clk            in   1    single clock, rising-edge
//   rst            in   1    asynchronous active-high reset
//   in_valid       in   1    plaintext block offered
//   in_ready       out  1    block accepted this cycle (IDLE only)
//   in_data        in   128  plaintext block
//   rk_idx         out  4    round-key index to the key schedule (0..10)
//   rk_in          in   128  round key for rk_idx, same-cycle lookup
//   dp_state_in    out  128  round datapath state input
//   dp_round_key   out  128  round datapath key
//   dp_sel_mix_col out  1    datapath MixColumns enable
//   dp_state_out   in   128  datapath result, 2-cycle registered latency
//   out_valid      out  1    ciphertext available
//   out_ready      in   1    consumer accepts ciphertext
//   out_data       out  128  ciphertext (zero while out_valid is low)
//   busy           out  1    block in flight
//   blk_cnt        out  16   completed-block count
//
// Configuration:
//   AES_CTRL_PERF_CNT_EN  when defined, blk_cnt counts output handshakes
//                         (wrapping at 16 bits). When undefined, blk_cnt is
//                         tied to zero and no counter register exists.
// ---------------------------------------------------------------------------
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] dp_state_in,
  output logic [127:0] dp_round_key,
  output logic         dp_sel_mix_col,
  input  logic [127:0] dp_state_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [15:0]  blk_cnt
);

  localparam logic [3:0] LastRound = 4'd10;
  localparam logic [1:0] LastPhase = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [127:0]   data_q;
  logic [3:0]     round_q;
  logic [1:0]     phase_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           mix_col_q;

  // Main controller FSM. All handshake and datapath-control outputs are
  // registered here and updated together with the state they belong to.
  // round_q returns to zero outside RUN, so it can drive rk_idx directly and
  // the key schedule sees index 0 in IDLE. That index-0 key is what the
  // initial AddRoundKey uses when a block is accepted.
  // The datapath has a 2-cycle latency, so in phase 2 dp_state_out holds the
  // round result for the state presented in phase 0. That result is captured
  // at the end of phase 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      round_q     <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mix_col_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data ^ rk_in;
            round_q    <= 4'd1;
            phase_q    <= 2'd0;
            mix_col_q  <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (phase_q == LastPhase) begin
            data_q  <= dp_state_out;
            phase_q <= 2'd0;
            if (round_q == LastRound) begin
              round_q     <= 4'd0;
              mix_col_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              round_q   <= round_q + 4'd1;
              // The final round skips MixColumns.
              mix_col_q <= (round_q != (LastRound - 4'd1));
            end
          end else begin
            phase_q <= phase_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign rk_idx         = round_q;
  assign dp_round_key   = rk_in;
  assign dp_state_in    = data_q;
  assign dp_sel_mix_col = mix_col_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  // Gate the data so stale results never leak onto the output bus.
  assign out_data       = out_valid_q ? data_q : '0;

`ifdef AES_CTRL_PERF_CNT_EN
  logic [15:0] blk_cnt_q;
  logic [15:0] blk_cnt_d;

  // Count every completed output handshake. The count wraps naturally at
  // 16 bits.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_valid_q && out_ready) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Self-checking bench for aes_round_ctrl. It contains a behavioural AES-128
// key schedule (combinational lookup by rk_idx) and a round datapath with
// 2-cycle registered latency. Both are built from a GF(2^8)-derived S-box, so
// the controller is exercised end to end against known FIPS-197 ciphertexts.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic [127:0] dp_state_in;
  logic [127:0] dp_round_key;
  logic         dp_sel_mix_col;
  logic [127:0] dp_state_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [15:0]  blk_cnt;

  int           checks;
  int           errors;
  logic [15:0]  expCnt;

  logic [7:0]   sbox   [256];
  logic [127:0] rkTab  [11];
  logic [127:0] dpPipe;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .rk_idx         (rk_idx),
    .rk_in          (rk_in),
    .dp_state_in    (dp_state_in),
    .dp_round_key   (dp_round_key),
    .dp_sel_mix_col (dp_sel_mix_col),
    .dp_state_out   (dp_state_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .blk_cnt        (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // The S-box is the multiplicative inverse followed by the affine transform.
  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      end
      b = inv;
      sbox[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  // Byte i of the state sits in row i%4, column i/4.
  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic mix);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = t[i];
    return res ^ k;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkTab[0];
    for (int r = 1; r <= 10; r++) s = aesRound(s, rkTab[r], r != 10);
    return s;
  endfunction

  // Key schedule: same-cycle lookup by index.
  assign rk_in = (rk_idx <= 4'd10) ? rkTab[rk_idx] : '0;

  // Round datapath with two register stages.
  always @(posedge clk) begin
    dpPipe       <= aesRound(dp_state_in, dp_round_key, dp_sel_mix_col);
    dp_state_out <= dpPipe;
  end

  function automatic logic [15:0] cntExpect();
`ifdef AES_CTRL_PERF_CNT_EN
    return expCnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic acceptBlock(input logic [127:0] pt);
    checkOutput("in_ready_idle", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = pt;
    stepCycle();
    in_valid = 1'b0;
  endtask

  // Run one block. When hold > 0, out_ready stays low for that many DONE
  // cycles before the handshake. With monitor set, the round sequencing is
  // checked on every RUN cycle. During those cycles a spurious in_valid is
  // offered, and it must be ignored.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] expCt,
                               input int hold, input bit monitor);
    int           n;
    int           r;
    logic [127:0] held;
    out_ready = (hold == 0);
    acceptBlock(pt);
    n = 1;
    held = '0;
    while (!out_valid && n < 60) begin
      if (monitor && n <= 30) begin
        r = (n - 1) / 3 + 1;
        checkOutput("rk_idx", 128'(rk_idx), 128'(r));
        checkOutput("mix_col", 128'(dp_sel_mix_col), 128'(r != 10));
        checkOutput("in_ready_run", 128'(in_ready), 128'd0);
        checkOutput("out_data_zero", out_data, 128'd0);
        if ((n - 1) % 3 == 0) held = dp_state_in;
        if ((n - 1) % 3 == 1) checkOutput("dp_state_hold", dp_state_in, held);
        in_valid = 1'b1;
        in_data  = ~pt;
      end
      stepCycle();
      n++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 128'(n), 128'd31);
    checkOutput("ciphertext", out_data, expCt);
    checkOutput("mix_col_done", 128'(dp_sel_mix_col), 128'd0);
    for (int i = 0; i < hold; i++) begin
      stepCycle();
      checkOutput("bp_valid", 128'(out_valid), 128'd1);
      checkOutput("bp_data", out_data, expCt);
      checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
      checkOutput("bp_busy", 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    stepCycle();
    expCnt = expCnt + 16'd1;
    checkOutput("idle_valid", 128'(out_valid), 128'd0);
    checkOutput("idle_in_ready", 128'(in_ready), 128'd1);
    checkOutput("idle_busy", 128'(busy), 128'd0);
    checkOutput("idle_data", out_data, 128'd0);
    checkOutput("blk_cnt", 128'(blk_cnt), 128'(cntExpect()));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_rk_idx", 128'(rk_idx), 128'd0);
    checkOutput("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expCnt = 16'h0000;
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int seen;
    logic [127:0] pts [3];
    checks    = 0;
    errors    = 0;
    expCnt    = 16'h0000;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    buildSbox();
    expandKey(KeyC1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    checkOutput("reset_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_rk_idx", 128'(rk_idx), 128'd0);
    checkOutput("reset_blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("reset_data", out_data, 128'd0);
    checkOutput("reset_mix_col", 128'(dp_sel_mix_col), 128'd0);
    checkOutput("reset_dp_state", dp_state_in, 128'd0);
    rst = 1'b0;
    stepCycle();

    // FIPS-197 appendix C.1 with full sequencing monitor
    applyStimulus(PtC1, CtC1, 0, 1'b1);

    // Backpressure: consumer stalls for five cycles
    applyStimulus(PtC1, CtC1, 5, 1'b0);

    // Mid-block reset: no output may appear for the discarded block
    acceptBlock(PtC1);
    repeat (14) stepCycle();
    pulseReset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      stepCycle();
    end
    checkOutput("no_out_after_rst", 128'(seen), 128'd0);
    applyStimulus(PtC1, CtC1, 0, 1'b0);

    // FIPS-197 appendix B vector under a different key
    expandKey(KeyB);
    applyStimulus(PtB, CtB, 0, 1'b0);
    expandKey(KeyC1);

    // Three back-to-back blocks from a clean count
    pulseReset();
    pts[0] = 128'h0;
    pts[1] = {128{1'b1}};
    pts[2] = 128'h0123456789abcdeffedcba9876543210;
    for (int i = 0; i < 3; i++) applyStimulus(pts[i], aesEncrypt(pts[i]), 0, 1'b0);
    checkOutput("blk_cnt_three", 128'(blk_cnt), 128'(cntExpect()));

`ifdef AES_CTRL_PERF_CNT_EN
    // Counter wrap from the top of its range
    dut.blk_cnt_q = 16'hFFFF;
    expCnt = 16'hFFFF;
    applyStimulus(PtC1, CtC1, 0, 1'b0);
    checkOutput("blk_cnt_wrap", 128'(blk_cnt), 128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
